// File: rtl/scan_pattern_driver_pkg.sv
// Shared types and constants for the scan pattern driver and its MISR.
// Package name patgen_pkg is shared with other test-case harnesses.
package patgen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] MISR_POLY     = 16'h1021;
  // x^7 + x^6 + 1: feedback taps on bits 6 and 5
  localparam int          LFSR_TAP_HI   = 6;
  localparam int          LFSR_TAP_LO   = 5;
  localparam logic [6:0]  ZERO_SEED_FIX = 7'h01;

endpackage

// File: rtl/scan_pattern_driver_if.sv
// Stimulus/response and status bundle between the pattern driver and its harness.
// master = pattern driver side, slave = harness/test side.
interface scan_pattern_driver_if #(
  parameter int PAT_W = 7,
  parameter int SIG_W = 16
) ();

  logic             start;
  logic [PAT_W-1:0] a;
  logic             b;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [7:0]       pat_cnt;

  modport master (
    input  start, b,
    output a, busy, done, signature, pat_cnt
  );

  modport slave (
    output start, b,
    input  a, busy, done, signature, pat_cnt
  );

endinterface

// File: rtl/scan_pattern_driver_misr_serial.sv
// Serial-input MISR; shifts one response bit per enabled edge into a CRC-style register.
// Synchronous clr has priority over en.
module misr_serial
  import patgen_pkg::*;
#(
  parameter int             W    = 16,
  parameter logic [W-1:0]   POLY = MISR_POLY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] sig
);

  logic fb;

  assign fb = sig[W-1] ^ din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/scan_pattern_driver.sv
// Pattern generator + response compactor for a clocked test circuit.
// Optional build macro PATGEN_EXHAUSTIVE_EN swaps the LFSR for a binary up-counter.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | one pattern per edge on a
// DRAIN | a held at 0, collecting the delayed responses
// DONE  | signature and pat_cnt frozen; start restarts
module scan_pattern_driver
  import patgen_pkg::*;
#(
  parameter int             PAT_W        = 7,
  parameter int             SIG_W        = 16,
  parameter int             DUT_LATENCY  = 2,
  parameter int             NUM_PATTERNS = 127,
  parameter logic [PAT_W-1:0] LFSR_SEED  = 7'h01
) (
  input  logic                  clk,
  input  logic                  rst,
  scan_pattern_driver_if.master bus
);

  localparam int CYC_W = 16;
  localparam logic [CYC_W-1:0] CAP_FIRST = CYC_W'(DUT_LATENCY);

`ifdef PATGEN_EXHAUSTIVE_EN
  localparam logic [PAT_W-1:0] FIRST_PAT = '0;
`else
  localparam logic [PAT_W-1:0] FIRST_PAT = (LFSR_SEED == '0) ? ZERO_SEED_FIX : LFSR_SEED;
`endif

  state_t           state, state_nxt;
  logic [PAT_W-1:0] a_q;
  logic [7:0]       pat_cnt_q;
  logic [7:0]       cap_cnt;
  logic [CYC_W-1:0] cyc;
  logic             busy;
  logic             accept;
  logic             last_pat;
  logic             cap_en;
  logic             last_cap;
  logic [PAT_W-1:0] pat_next;

`ifdef PATGEN_EXHAUSTIVE_EN
  assign pat_next = a_q + 1'b1;
`else
  assign pat_next = {a_q[PAT_W-2:0], a_q[LFSR_TAP_HI] ^ a_q[LFSR_TAP_LO]};
`endif

  assign busy     = (state == RUN) || (state == DRAIN);
  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign last_pat = (pat_cnt_q == 8'(NUM_PATTERNS));
  // Capture window opens when cyc reaches the latency and stays open for NUM_PATTERNS samples
  assign cap_en   = busy && ((cap_cnt != 8'd0) || (cyc == CAP_FIRST))
                    && (cap_cnt != 8'(NUM_PATTERNS));
  assign last_cap = cap_en && (cap_cnt == 8'(NUM_PATTERNS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = RUN;
      RUN:        if (last_pat)  state_nxt = last_cap ? DONE : DRAIN;
      DRAIN:      if (last_cap)  state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      pat_cnt_q <= '0;
      cap_cnt   <= '0;
      cyc       <= '0;
    end else if (accept) begin
      a_q       <= FIRST_PAT;
      pat_cnt_q <= 8'd1;
      cap_cnt   <= '0;
      cyc       <= '0;
    end else if (busy) begin
      cyc <= cyc + 1'b1;
      if (cap_en) cap_cnt <= cap_cnt + 8'd1;
      if (state == RUN) begin
        if (last_pat) begin
          a_q <= '0;
        end else begin
          a_q       <= pat_next;
          pat_cnt_q <= pat_cnt_q + 8'd1;
        end
      end
    end
  end

  misr_serial #(
    .W    (SIG_W),
    .POLY (SIG_W'(MISR_POLY))
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (cap_en),
    .din (bus.b),
    .sig (bus.signature)
  );

  assign bus.a       = a_q;
  assign bus.busy    = busy;
  assign bus.done    = (state == DONE);
  assign bus.pat_cnt = pat_cnt_q;

endmodule

// File: tb/tb_scan_pattern_driver.sv
// Directed bench for scan_pattern_driver: cycle table for the main run plus
// hand sequences for reset abort, latency alignment and full-length runs.
module tb_scan_pattern_driver;

  logic clk = 1'b0;
  logic rst;
  logic loop_main;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  scan_pattern_driver_if #(.PAT_W(7), .SIG_W(16)) if_main ();
  scan_pattern_driver_if #(.PAT_W(7), .SIG_W(16)) if_n1 ();
  scan_pattern_driver_if #(.PAT_W(7), .SIG_W(16)) if_n2 ();
  scan_pattern_driver_if #(.PAT_W(7), .SIG_W(16)) if_l1 ();
  scan_pattern_driver_if #(.PAT_W(7), .SIG_W(16)) if_ex ();

  scan_pattern_driver #(.DUT_LATENCY(2), .NUM_PATTERNS(8))   u_main (.clk(clk), .rst(rst), .bus(if_main));
  scan_pattern_driver #(.DUT_LATENCY(2), .NUM_PATTERNS(1))   u_n1   (.clk(clk), .rst(rst), .bus(if_n1));
  scan_pattern_driver #(.DUT_LATENCY(2), .NUM_PATTERNS(2))   u_n2   (.clk(clk), .rst(rst), .bus(if_n2));
  scan_pattern_driver #(.DUT_LATENCY(1), .NUM_PATTERNS(8))   u_l1   (.clk(clk), .rst(rst), .bus(if_l1));
  scan_pattern_driver #(.DUT_LATENCY(2), .NUM_PATTERNS(128)) u_ex   (.clk(clk), .rst(rst), .bus(if_ex));

  // Two-flop stand-ins for the circuit under test: b = a[0] delayed two edges
  logic [1:0] ch_main, ch_l1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_main <= '0;
      ch_l1   <= '0;
    end else begin
      ch_main <= {ch_main[0], if_main.a[0]};
      ch_l1   <= {ch_l1[0], if_l1.a[0]};
    end
  end

  assign if_main.b = loop_main ? ch_main[1] : 1'b0;
  assign if_n1.b   = 1'b1;
  assign if_n2.b   = 1'b1;
  assign if_l1.b   = ch_l1[1];
  assign if_ex.b   = 1'b0;

  typedef struct {
    logic       start;
    logic       loop;
    logic [6:0] a;
    logic       busy;
    logic       done;
    logic [7:0] pc;
  } vec_t;

  vec_t       tv[13];
  logic [6:0] exp_pat[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic d);
    logic fb;
    fb = s[15] ^ d;
    return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [6:0] pat_ref_next(input logic [6:0] p);
`ifdef PATGEN_EXHAUSTIVE_EN
    return p + 7'd1;
`else
    return {p[5:0], p[6] ^ p[5]};
`endif
  endfunction

  initial begin
    logic [15:0] sig_main_ref, sig_l1_ref, sig_part;
    logic [6:0]  p;
    logic [127:0] seen;
    int          distinct;

`ifdef PATGEN_EXHAUSTIVE_EN
    exp_pat = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07};
`else
    exp_pat = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
`endif
    for (int i = 0; i < 8; i++)
      tv[i] = '{start: (i == 0 || i == 3), loop: 1'b0, a: exp_pat[i],
                busy: 1'b1, done: 1'b0, pc: 8'(i + 1)};
    tv[8]  = '{start: 1'b0, loop: 1'b0, a: 7'h00, busy: 1'b1, done: 1'b0, pc: 8'd8};
    tv[9]  = '{start: 1'b1, loop: 1'b0, a: 7'h00, busy: 1'b1, done: 1'b0, pc: 8'd8};
    tv[10] = '{start: 1'b0, loop: 1'b0, a: 7'h00, busy: 1'b0, done: 1'b1, pc: 8'd8};
    tv[11] = '{start: 1'b0, loop: 1'b0, a: 7'h00, busy: 1'b0, done: 1'b1, pc: 8'd8};
    tv[12] = '{start: 1'b1, loop: 1'b1, a: exp_pat[0], busy: 1'b1, done: 1'b0, pc: 8'd1};

    sig_main_ref = '0;
    for (int k = 0; k < 8; k++) sig_main_ref = misr_ref(sig_main_ref, exp_pat[k][0]);
    sig_l1_ref = misr_ref(16'h0000, 1'b0);
    for (int k = 0; k < 7; k++) sig_l1_ref = misr_ref(sig_l1_ref, exp_pat[k][0]);
    sig_part = misr_ref(misr_ref(16'h0000, exp_pat[0][0]), exp_pat[1][0]);

    rst = 1'b1;
    loop_main = 1'b0;
    if_main.start = 1'b0;
    if_n1.start = 1'b0;
    if_n2.start = 1'b0;
    if_l1.start = 1'b0;
    if_ex.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a", 32'(if_main.a), 32'h0);
    chk("rst_busy", 32'(if_main.busy), 32'h0);
    chk("rst_done", 32'(if_main.done), 32'h0);
    chk("rst_sig", 32'(if_main.signature), 32'h0);
    chk("rst_pc", 32'(if_main.pat_cnt), 32'h0);

    // Cycle table: run with b=0, start pulses in RUN/DRAIN, then restart from DONE
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if_main.start = tv[i].start;
      loop_main     = tv[i].loop;
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d_a", i), 32'(if_main.a), 32'(tv[i].a));
      chk($sformatf("tv%0d_busy", i), 32'(if_main.busy), 32'(tv[i].busy));
      chk($sformatf("tv%0d_done", i), 32'(if_main.done), 32'(tv[i].done));
      chk($sformatf("tv%0d_pc", i), 32'(if_main.pat_cnt), 32'(tv[i].pc));
      chk($sformatf("tv%0d_sig", i), 32'(if_main.signature), 32'h0);
    end
    @(negedge clk);
    if_main.start = 1'b0;

    for (int k = 0; k < 30 && !if_main.done; k++) @(negedge clk);
    chk("loop_done", 32'(if_main.done), 32'h1);
    chk("loop_sig", 32'(if_main.signature), 32'(sig_main_ref));
    chk("loop_pc", 32'(if_main.pat_cnt), 32'd8);

    // Abort at pattern 5 via reset, then rerun
    @(negedge clk);
    if_main.start = 1'b1;
    @(negedge clk);
    if_main.start = 1'b0;
    for (int k = 0; k < 20 && if_main.pat_cnt != 8'd5; k++) @(negedge clk);
    chk("abort_pc5", 32'(if_main.pat_cnt), 32'd5);
    chk("abort_partial_sig", 32'(if_main.signature), 32'(sig_part));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_a", 32'(if_main.a), 32'h0);
    chk("abort_busy", 32'(if_main.busy), 32'h0);
    chk("abort_done", 32'(if_main.done), 32'h0);
    chk("abort_sig", 32'(if_main.signature), 32'h0);
    chk("abort_pc", 32'(if_main.pat_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    if_main.start = 1'b1;
    @(posedge clk);
    #1;
    chk("rerun_a", 32'(if_main.a), 32'(exp_pat[0]));
    chk("rerun_pc", 32'(if_main.pat_cnt), 32'd1);
    @(negedge clk);
    if_main.start = 1'b0;
    for (int k = 0; k < 30 && !if_main.done; k++) @(negedge clk);
    chk("rerun_done", 32'(if_main.done), 32'h1);
    chk("rerun_sig", 32'(if_main.signature), 32'(sig_main_ref));

    // Short runs and latency alignment, started together
    @(negedge clk);
    if_n1.start = 1'b1;
    if_n2.start = 1'b1;
    if_l1.start = 1'b1;
    @(negedge clk);
    if_n1.start = 1'b0;
    if_n2.start = 1'b0;
    if_l1.start = 1'b0;
    for (int k = 0; k < 30 && !(if_n1.done && if_n2.done && if_l1.done); k++) @(negedge clk);
    chk("n1_done", 32'(if_n1.done), 32'h1);
    chk("n1_sig", 32'(if_n1.signature), 32'h1021);
    chk("n1_pc", 32'(if_n1.pat_cnt), 32'd1);
    chk("n2_done", 32'(if_n2.done), 32'h1);
    chk("n2_sig", 32'(if_n2.signature), 32'h3063);
    chk("n2_pc", 32'(if_n2.pat_cnt), 32'd2);
    chk("l1_done", 32'(if_l1.done), 32'h1);
    chk("l1_sig", 32'(if_l1.signature), 32'(sig_l1_ref));
    chk("l1_differs", 32'(if_l1.signature != sig_main_ref), 32'h1);

    // Full-length run: 128 patterns then drain
    @(negedge clk);
    if_ex.start = 1'b1;
    @(posedge clk);
    #1;
    if_ex.start = 1'b0;
`ifdef PATGEN_EXHAUSTIVE_EN
    p = 7'h00;
`else
    p = 7'h01;
`endif
    seen = '0;
    for (int k = 1; k <= 128; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("ex_a%0d", k), 32'(if_ex.a), 32'(p));
      seen[if_ex.a] = 1'b1;
      p = pat_ref_next(p);
    end
    distinct = 0;
    for (int k = 0; k < 128; k++) if (seen[k]) distinct++;
`ifdef PATGEN_EXHAUSTIVE_EN
    chk("ex_distinct", 32'(distinct), 32'd128);
`else
    chk("ex_distinct", 32'(distinct), 32'd127);
`endif
    chk("ex_pc", 32'(if_ex.pat_cnt), 32'd128);
    @(posedge clk);
    #1;
    chk("ex_e128_a", 32'(if_ex.a), 32'h0);
    chk("ex_e128_done", 32'(if_ex.done), 32'h0);
    @(posedge clk);
    #1;
    chk("ex_e129_done", 32'(if_ex.done), 32'h0);
    @(posedge clk);
    #1;
    chk("ex_e130_done", 32'(if_ex.done), 32'h1);
    chk("ex_e130_pc", 32'(if_ex.pat_cnt), 32'd128);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
